// File: rtl/state_pkg.sv
// Shared types and placement helper for the word-serial state packer family.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
//
// Contents:
//   DEF_BYTE_W / DEF_NUM_WORDS : default state geometry (8-bit bytes, 4x4 state)
//   MAX_*                      : upper bounds on geometry supported by place_word
//   pack_mode_t                : column-word or row-word block interpretation
//   out_st_t                   : output-stage occupancy (empty / full / full+pending)
//   place_word()               : returns a state with one word inserted at index idx
package state_pkg;

    localparam int DEF_BYTE_W    = 8;
    localparam int DEF_NUM_WORDS = 4;

    // place_word works on fixed maximum-size vectors so one function serves
    // every geometry; callers zero-extend into it and truncate the result.
    localparam int MAX_BYTE_W   = 16;
    localparam int MAX_WORDS    = 8;
    localparam int MAX_WORD_W   = MAX_BYTE_W * MAX_WORDS;
    localparam int MAX_STATE_W  = MAX_WORDS * MAX_WORD_W;
    localparam int MAX_SIDX_W   = $clog2(MAX_STATE_W);
    localparam int MAX_WIDX_W   = $clog2(MAX_WORD_W);

    typedef enum logic {
        MODE_COL = 1'b0,
        MODE_ROW = 1'b1
    } pack_mode_t;

    typedef enum logic [1:0] {
        OS_EMPTY = 2'd0,
        OS_FULL  = 2'd1,
        OS_PEND  = 2'd2
    } out_st_t;

    // Column mode: word idx is state column idx.
    // Row mode:    byte c of word idx lands at (row idx, column c).
    // byte_w / num_words are elaboration constants at every call site, so the
    // loop bounds collapse to the real geometry in synthesis.
    function automatic logic [MAX_STATE_W-1:0] place_word(
        input logic [MAX_STATE_W-1:0] state,
        input logic [MAX_WORD_W-1:0]  word,
        input int unsigned            idx,
        input pack_mode_t             mode,
        input int unsigned            byte_w,
        input int unsigned            num_words
    );
        logic [MAX_STATE_W-1:0] res;
        int unsigned            word_w;
        int unsigned            dst;
        int unsigned            src;
        res    = state;
        word_w = byte_w * num_words;
        for (int unsigned c = 0; c < MAX_WORDS; c++) begin
            for (int unsigned k = 0; k < MAX_BYTE_W; k++) begin
                if ((c < num_words) && (k < byte_w)) begin
                    src = c * byte_w + k;
                    if (mode == MODE_COL) begin
                        dst = idx * word_w + c * byte_w + k;
                    end else begin
                        dst = (c * num_words + idx) * byte_w + k;
                    end
                    if (dst < MAX_STATE_W) begin
                        res[MAX_SIDX_W'(dst)] = word[MAX_WIDX_W'(src)];
                    end
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/state_out_reg.sv
// Output register with one block of pending storage behind it, valid/ready out.
// Latency: a block offered on blk_vld is visible on out_state the next cycle when the register is free.
// Backpressure: a block arriving while the register is held becomes pending (pend=1) until the next out handshake.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous abort, drops pending block and output valid
//   blk_vld     : a completed block (blk_dat) is offered this cycle
//   blk_dat     : the completed block
//   buf_dat     : caller-owned storage holding the pending block while pend=1
//   pend        : a block is waiting in buf_dat; caller must not offer another
//   out_valid / out_ready / out_state : downstream stream
module state_out_reg
    import state_pkg::*;
#(
    parameter int STATE_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               blk_vld,
    input  logic [STATE_W-1:0] blk_dat,
    input  logic [STATE_W-1:0] buf_dat,
    output logic               pend,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    out_st_t            st_q;
    out_st_t            st_d;
    logic               out_fire;
    logic               load_new;
    logic               load_buf;
    logic [STATE_W-1:0] out_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= OS_EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state
    always_comb begin
        st_d = st_q;
        if (clear) begin
            st_d = OS_EMPTY;
        end else begin
            case (st_q)
                OS_EMPTY: begin
                    if (blk_vld) st_d = OS_FULL;
                end
                OS_FULL: begin
                    // A handshake in the completion cycle frees the register
                    // for the new block directly.
                    if (blk_vld) begin
                        st_d = out_fire ? OS_FULL : OS_PEND;
                    end else if (out_fire) begin
                        st_d = OS_EMPTY;
                    end
                end
                OS_PEND: begin
                    if (out_fire) st_d = OS_FULL;
                end
                default: st_d = OS_EMPTY;
            endcase
        end
    end

    // Outputs and register load strobes
    always_comb begin
        out_valid = (st_q != OS_EMPTY);
        pend      = (st_q == OS_PEND);
        out_fire  = out_valid & out_ready;
        load_new  = 1'b0;
        load_buf  = 1'b0;
        if (!clear) begin
            load_buf = (st_q == OS_PEND) & out_fire;
            load_new = blk_vld & ((st_q == OS_EMPTY) | ((st_q == OS_FULL) & out_fire));
        end
    end

    // Output data is never cleared except by reset; it holds after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (load_buf) begin
            out_q <= buf_dat;
        end else if (load_new) begin
            out_q <= blk_dat;
        end
    end

    assign out_state = out_q;

endmodule

// File: rtl/state_word_packer.sv
// Word-serial AES state assembler: NUM_WORDS words in, one packed row- or column-ordered state out.
// Latency: state valid 1 cycle after the last word is accepted; one word per cycle sustained.
// Backpressure: one complete block is buffered; in_ready drops only while that block waits for the output.
//
// Optional feature: define STATE_PACK_CNT_EN to add blk_cnt, a saturating
// 16-bit count of output handshakes (reset 0, cleared by clear).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort of partial block, pending block and output valid
//   in_mode    : 0 = column words, 1 = row words; sampled with word 0 only
//   in_valid / in_ready / in_word     : word input stream
//   out_valid / out_ready / out_state : packed state stream;
//                column c at [c*WORD_W +: WORD_W], row r at [r*BYTE_W +: BYTE_W] within it
//   blk_cnt    : (STATE_PACK_CNT_EN only) delivered-state count
module state_word_packer
    import state_pkg::*;
#(
    parameter int BYTE_W    = DEF_BYTE_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int WORD_W    = NUM_WORDS * BYTE_W,
    parameter int STATE_W   = NUM_WORDS * WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
`ifdef STATE_PACK_CNT_EN
    ,
    output logic [15:0]        blk_cnt
`endif
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // WORD_W and STATE_W are derived; overriding them breaks the placement map.
    if (WORD_W != NUM_WORDS * BYTE_W) begin : g_bad_word_w
        $error("state_word_packer: WORD_W must equal NUM_WORDS*BYTE_W");
    end
    if (STATE_W != NUM_WORDS * WORD_W) begin : g_bad_state_w
        $error("state_word_packer: STATE_W must equal NUM_WORDS*WORD_W");
    end
    if ((NUM_WORDS > MAX_WORDS) || (BYTE_W > MAX_BYTE_W)) begin : g_too_big
        $error("state_word_packer: geometry exceeds state_pkg limits");
    end

    logic [IDX_W-1:0]   idx_q;
    pack_mode_t         mode_q;
    pack_mode_t         cur_mode;
    logic [STATE_W-1:0] asm_q;
    logic [STATE_W-1:0] placed;
    logic               accept;
    logic               last_word;
    logic               blk_vld;
    logic               pend;

    // in_ready depends on registered state only.
    assign in_ready  = ~pend;
    assign accept    = in_valid & in_ready & ~clear;
    assign last_word = (idx_q == LAST_IDX);
    assign blk_vld   = accept & last_word;

    // Word 0 takes the live mode; later words follow the latched one.
    assign cur_mode = (idx_q == '0) ? pack_mode_t'(in_mode) : mode_q;

    assign placed = STATE_W'(place_word(MAX_STATE_W'(asm_q), MAX_WORD_W'(in_word),
                                        32'(idx_q), cur_mode, BYTE_W, NUM_WORDS));

    // The assembly buffer doubles as the pending block store: once the last
    // word lands it holds the full state, and no word is accepted until the
    // output stage has taken it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            mode_q <= MODE_COL;
            asm_q  <= '0;
        end else if (clear) begin
            idx_q  <= '0;
        end else if (accept) begin
            asm_q  <= placed;
            idx_q  <= last_word ? '0 : idx_q + 1'b1;
            if (idx_q == '0) begin
                mode_q <= cur_mode;
            end
        end
    end

    state_out_reg #(
        .STATE_W (STATE_W)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .blk_vld   (blk_vld),
        .blk_dat   (placed),
        .buf_dat   (asm_q),
        .pend      (pend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

`ifdef STATE_PACK_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (clear) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready && (blk_cnt != 16'hFFFF)) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule
